// File: rtl/trace_hart_arbiter.sv
// Round-robin merge of per-hart retire-record FIFOs into one
// registered valid/ready output slot tagged with hart id and order.
//
// Ports:
//   clk, reset_n           clock, async active-low reset
//   req_valid/ready/rec    per-hart push side (rec packed h*REC_W)
//   out_valid/ready        output slot handshake
//   out_rec/hart/order     record, source hart, per-hart order number
//   fifo_empty             per-hart FIFO empty status
//   stall_err              sticky stall watchdog flag, present only
//                          when TRACE_HART_ARB_WATCHDOG_EN is defined
module trace_hart_arbiter #(
  parameter int NHART   = 2,
  parameter int REC_W   = 128,
  parameter int DEPTH   = 4,
  parameter int ORDER_W = 64,
  parameter int TIMEOUT = 1024,
  localparam int HW = (NHART > 1) ? $clog2(NHART) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NHART-1:0]       req_valid,
  output logic [NHART-1:0]       req_ready,
  input  logic [NHART*REC_W-1:0] req_rec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [REC_W-1:0]       out_rec,
  output logic [HW-1:0]          out_hart,
  output logic [ORDER_W-1:0]     out_order,
  output logic [NHART-1:0]       fifo_empty
`ifdef TRACE_HART_ARB_WATCHDOG_EN
  ,
  output logic                   stall_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [REC_W-1:0]   r_mem [NHART][DEPTH];
  logic [PW-1:0]      r_wp [NHART];
  logic [PW-1:0]      r_rp [NHART];
  logic [ORDER_W-1:0] r_order [NHART];
  logic [HW-1:0]      r_ptr;

  logic               r_out_valid;
  logic [REC_W-1:0]   r_out_rec;
  logic [HW-1:0]      r_out_hart;
  logic [ORDER_W-1:0] r_out_order;

  logic [NHART-1:0]   w_empty;
  logic [NHART-1:0]   w_full;
  logic [NHART-1:0]   w_push;
  logic [NHART-1:0]   w_pop;
  logic               w_any;
  logic               w_load;
  logic               w_found;
  logic [HW-1:0]      w_idx;
  logic [HW-1:0]      w_gnt;
  logic [HW-1:0]      w_ptr_nxt;
  logic [REC_W-1:0]   w_head;

  // Pointers carry one extra wrap bit so full and empty differ.
  always_comb begin
    w_empty = '0;
    w_full  = '0;
    w_push  = '0;
    for (int h = 0; h < NHART; h++) begin
      w_empty[h] = (r_wp[h] == r_rp[h]);
      w_full[h]  = (r_wp[h][AW] != r_rp[h][AW]) &&
                   (r_wp[h][AW-1:0] == r_rp[h][AW-1:0]);
      w_push[h]  = req_valid[h] & ~w_full[h];
    end
  end

  assign w_any  = |(~w_empty);
  assign w_load = (~r_out_valid | out_ready) & w_any;

  // First non-empty hart scanning upward from the rr pointer.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    for (int i = 0; i < NHART; i++) begin
      w_idx = HW'((32'(r_ptr) + 32'(i)) % NHART);
      if (!w_found && !w_empty[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = w_idx;
      end
    end
  end

  assign w_ptr_nxt = HW'((32'(w_gnt) + 32'd1) % NHART);
  assign w_head    = r_mem[w_gnt][r_rp[w_gnt][AW-1:0]];

  always_comb begin
    w_pop = '0;
    if (w_load) w_pop[w_gnt] = 1'b1;
  end

  // Storage is left unreset; emptiness comes from the pointers.
  always_ff @(posedge clk) begin
    for (int h = 0; h < NHART; h++) begin
      if (w_push[h])
        r_mem[h][r_wp[h][AW-1:0]] <= req_rec[h*REC_W +: REC_W];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int h = 0; h < NHART; h++) begin
        r_wp[h]    <= '0;
        r_rp[h]    <= '0;
        r_order[h] <= ORDER_W'(1);
      end
    end else begin
      for (int h = 0; h < NHART; h++) begin
        if (w_push[h]) r_wp[h] <= r_wp[h] + PW'(1);
        if (w_pop[h]) begin
          r_rp[h]    <= r_rp[h] + PW'(1);
          r_order[h] <= r_order[h] + ORDER_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_rec   <= '0;
      r_out_hart  <= '0;
      r_out_order <= '0;
    end else if (w_load) begin
      r_ptr       <= w_ptr_nxt;
      r_out_valid <= 1'b1;
      r_out_rec   <= w_head;
      r_out_hart  <= w_gnt;
      r_out_order <= r_order[w_gnt];
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign req_ready  = ~w_full;
  assign fifo_empty = w_empty;
  assign out_valid  = r_out_valid;
  assign out_rec    = r_out_rec;
  assign out_hart   = r_out_hart;
  assign out_order  = r_out_order;

`ifdef TRACE_HART_ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_wd_cnt;
  logic [CW-1:0] w_wd_nxt;
  logic          r_stall_err;
  logic          w_stall;

  assign w_stall  = r_out_valid & ~out_ready;
  // Saturate at TIMEOUT so a long stall never wraps back to 0.
  assign w_wd_nxt = (r_wd_cnt == CW'(TIMEOUT)) ?
                    r_wd_cnt : r_wd_cnt + CW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wd_cnt    <= '0;
      r_stall_err <= 1'b0;
    end else if (w_stall) begin
      r_wd_cnt <= w_wd_nxt;
      if (w_wd_nxt == CW'(TIMEOUT)) r_stall_err <= 1'b1;
    end else begin
      r_wd_cnt <= '0;
    end
  end

  assign stall_err = r_stall_err;
`endif

endmodule

// File: tb/tb_trace_hart_arbiter.sv
// Self-checking bench for trace_hart_arbiter: directed scenarios
// plus random traffic against a queue-based reference model.
module tb_trace_hart_arbiter;

  localparam int N  = 3;
  localparam int RW = 16;
  localparam int D  = 4;
  localparam int OW = 4;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*RW-1:0] req_rec = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [RW-1:0]   out_rec;
  logic [1:0]      out_hart;
  logic [OW-1:0]   out_order;
  logic [N-1:0]    fifo_empty;
`ifdef TRACE_HART_ARB_WATCHDOG_EN
  logic            stall_err;
`endif

  int total  = 0;
  int passed = 0;
  int failed = 0;

  logic [RW-1:0] q [N][$];
  int            ord [N];
  int            ptr;
  bit            mv;
  logic [RW-1:0] mrec;
  int            mhart;
  int            mord;
  int            wd;
  bit            merr;

  always #5 clk = ~clk;

  trace_hart_arbiter #(
    .NHART(N), .REC_W(RW), .DEPTH(D),
    .ORDER_W(OW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rec(req_rec),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rec(out_rec), .out_hart(out_hart),
    .out_order(out_order), .fifo_empty(fifo_empty)
`ifdef TRACE_HART_ARB_WATCHDOG_EN
    , .stall_err(stall_err)
`endif
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int h = 0; h < N; h++) begin
      q[h].delete();
      ord[h] = 1;
    end
    ptr = 0; mv = 0; mrec = '0; mhart = 0; mord = 0;
    wd = 0; merr = 0;
  endtask

  // One clock edge of the specified behaviour, from pre-edge state.
  task automatic model_edge();
    bit rdy [N];
    bit any;
    bit stall;
    int g;
    any = 0;
    for (int h = 0; h < N; h++) begin
      rdy[h] = (q[h].size() < D);
      if (q[h].size() > 0) any = 1;
    end
    stall = mv && !out_ready;
    if ((!mv || out_ready) && any) begin
      g = -1;
      for (int i = 0; i < N; i++) begin
        int c;
        c = (ptr + i) % N;
        if (g < 0 && q[c].size() > 0) g = c;
      end
      mrec  = q[g].pop_front();
      mhart = g;
      mord  = ord[g];
      ord[g] = (ord[g] + 1) % (1 << OW);
      ptr   = (g + 1) % N;
      mv    = 1;
    end else if (out_ready) begin
      mv = 0;
    end
    for (int h = 0; h < N; h++)
      if (req_valid[h] && rdy[h])
        q[h].push_back(req_rec[h*RW +: RW]);
    if (stall) begin
      if (wd < TO) wd++;
      if (wd == TO) merr = 1;
    end else begin
      wd = 0;
    end
  endtask

  task automatic check_all();
    logic [N-1:0] er;
    logic [N-1:0] ee;
    for (int h = 0; h < N; h++) begin
      er[h] = (q[h].size() < D);
      ee[h] = (q[h].size() == 0);
    end
    chk("out_valid", out_valid, mv);
    if (mv) begin
      chk("out_rec", out_rec, mrec);
      chk("out_hart", out_hart, mhart);
      chk("out_order", out_order, mord);
    end
    chk("req_ready", req_ready, er);
    chk("fifo_empty", fifo_empty, ee);
`ifdef TRACE_HART_ARB_WATCHDOG_EN
    chk("stall_err", stall_err, merr);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    model_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_empty", fifo_empty, {N{1'b1}});
    chk("rst_ready", req_ready, {N{1'b1}});
    chk("rst_rec", out_rec, 0);
    chk("rst_hart", out_hart, 0);
    chk("rst_order", out_order, 0);
`ifdef TRACE_HART_ARB_WATCHDOG_EN
    chk("rst_stall", stall_err, 0);
`endif
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic set_rec(input int h, input logic [RW-1:0] v);
    req_rec[h*RW +: RW] = v;
  endtask

  initial begin
    logic [RW-1:0] exp_rec [4];
    int            exp_ord [4];
    int            cnt;
    exp_rec = '{16'hA0, 16'hB0, 16'hA1, 16'hB1};
    exp_ord = '{1, 1, 2, 2};

    #1;
    do_reset();

    // Single record, 2-cycle latency.
    out_ready = 1'b1;
    req_valid = 3'b001; set_rec(0, 16'h11);
    step();
    req_valid = '0;
    step();
    chk("t1_valid", out_valid, 1);
    chk("t1_rec", out_rec, 16'h11);
    chk("t1_hart", out_hart, 0);
    chk("t1_order", out_order, 1);
    step();
    chk("t1_clear", out_valid, 0);

    // Two harts interleave round-robin, one per cycle.
    do_reset();
    out_ready = 1'b1;
    req_valid = 3'b011;
    set_rec(0, 16'hA0); set_rec(1, 16'hB0);
    step();
    set_rec(0, 16'hA1); set_rec(1, 16'hB1);
    for (int i = 0; i < 4; i++) begin
      step();
      req_valid = '0;
      chk("t2_valid", out_valid, 1);
      chk("t2_rec", out_rec, exp_rec[i]);
      chk("t2_order", out_order, exp_ord[i]);
    end
    step();
    chk("t2_drain", out_valid, 0);

    // Backpressure: slot + full FIFO, stable hold, in-order drain.
    do_reset();
    out_ready = 1'b0;
    req_valid = 3'b010;
    for (int k = 0; k < 5; k++) begin
      set_rec(1, 16'hC0 + 16'(k));
      step();
    end
    req_valid = '0;
    chk("t3_full", req_ready[1], 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t3_hold", out_rec, 16'hC0);
    end
    out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      step();
      chk("t3_seq", out_rec, 16'hC0 + 16'(k));
    end
    step();
    chk("t3_done", out_valid, 0);

    // Order counter wraps modulo 2^OW.
    do_reset();
    out_ready = 1'b1;
    cnt = 0;
    for (int k = 1; k <= 19; k++) begin
      req_valid = (k <= 17) ? 3'b001 : 3'b000;
      set_rec(0, 16'(k));
      step();
      if (out_valid && out_hart == 2'd0) begin
        cnt++;
        chk("t4_order", out_order, cnt % 16);
      end
    end
    chk("t4_count", cnt, 17);

    // Asynchronous reset mid-operation.
    req_valid = '0;
    do_reset();
    out_ready = 1'b0;
    req_valid = 3'b011;
    set_rec(0, 16'h55); set_rec(1, 16'h66);
    step(); step(); step();
    req_valid = '0;
    chk("t5_pre", out_valid, 1);
    do_reset();
    out_ready = 1'b1;
    req_valid = 3'b010; set_rec(1, 16'h77);
    step();
    req_valid = '0;
    step();
    chk("t5_rec", out_rec, 16'h77);
    chk("t5_order", out_order, 1);

`ifdef TRACE_HART_ARB_WATCHDOG_EN
    // Stall watchdog: 8 stalled cycles set it, sticky.
    do_reset();
    out_ready = 1'b0;
    req_valid = 3'b001; set_rec(0, 16'h99);
    step();
    req_valid = '0;
    step();
    for (int i = 0; i < 7; i++) step();
    chk("wd_7", stall_err, 0);
    step();
    chk("wd_8", stall_err, 1);
    out_ready = 1'b1;
    step(); step();
    chk("wd_sticky", stall_err, 1);

    // 7 stalled cycles then a transfer: no error.
    do_reset();
    out_ready = 1'b0;
    req_valid = 3'b001; set_rec(0, 16'h9A);
    step();
    req_valid = '0;
    step();
    for (int i = 0; i < 7; i++) step();
    out_ready = 1'b1;
    step(); step();
    chk("wd_ok", stall_err, 0);
`endif

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req_valid = N'($urandom);
      for (int h = 0; h < N; h++) set_rec(h, RW'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      if (i == 200) begin
        req_valid = '0;
        do_reset();
      end else begin
        step();
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
